// File: rtl/ldpc_dec_ctrl.sv
// ldpc_dec_ctrl: frame sequencer for the layered LDPC decoder array.
// Per frame: load channel LLRs, alternate VNU/CNU phases, then check the
// hard-decision vector for stability or the iteration limit, and hand the
// decoded word out through a valid/ready handshake.
module ldpc_dec_ctrl #(
  parameter int R      = 5,
  parameter int C      = 3,
  parameter int D      = 8,
  parameter int ITER_W = 4,
  parameter int PH_LAT = 2,
  parameter int LD_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] max_iter,
  input  logic [R*D-1:0]    dec,
  output logic              ld_en,
  output logic              vnu_en,
  output logic              cnu_en,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [R*D-1:0]    out_dec,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_conv
);

  localparam int DW     = R * D;
  localparam int PH_MAX = (PH_LAT > LD_CYC) ? PH_LAT : LD_CYC;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH_LAT - 1);
  localparam logic [PH_W-1:0] LD_LAST = PH_W'(LD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_VNU   = 3'd2,
    S_CNU   = 3'd3,
    S_CHECK = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   lim_q, lim_d;
  logic [DW-1:0]       prev_q, prev_d;
  logic                ld_en_q, ld_en_d;
  logic                vnu_en_q, vnu_en_d;
  logic                cnu_en_q, cnu_en_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_dec_q, out_dec_d;
  logic [ITER_W-1:0]   out_iter_q, out_iter_d;
  logic                out_conv_q, out_conv_d;
  logic [ITER_W-1:0]   n_s;
  logic                stable_s;

  // Next-state, counters and registered-output precomputation.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    iter_d     = iter_q;
    lim_d      = lim_q;
    prev_d     = prev_q;
    out_dec_d  = out_dec_q;
    out_iter_d = out_iter_q;
    out_conv_d = out_conv_q;
    // Iteration number being completed; lim never exceeds 2^ITER_W-1 so no wrap.
    n_s        = iter_q + ITER_W'(1);
    // The first iteration has no predecessor, so it can never count as stable.
    stable_s   = (n_s >= ITER_W'(2)) && (dec == prev_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          lim_d   = (max_iter == '0) ? ITER_W'(1) : max_iter;
          iter_d  = '0;
          ph_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          ph_d    = '0;
        end else if (ph_q == LD_LAST) begin
          state_d = S_VNU;
          ph_d    = '0;
        end else begin
          ph_d    = ph_q + PH_W'(1);
        end
      end
      S_VNU: begin
        if (abort) begin
          state_d = S_IDLE;
          ph_d    = '0;
        end else if (ph_q == PH_LAST) begin
          state_d = S_CNU;
          ph_d    = '0;
        end else begin
          ph_d    = ph_q + PH_W'(1);
        end
      end
      S_CNU: begin
        if (abort) begin
          state_d = S_IDLE;
          ph_d    = '0;
        end else if (ph_q == PH_LAST) begin
          state_d = S_CHECK;
          ph_d    = '0;
        end else begin
          ph_d    = ph_q + PH_W'(1);
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (stable_s) begin
          state_d    = S_OUT;
          out_dec_d  = dec;
          out_iter_d = n_s;
          out_conv_d = 1'b1;
        end else if (n_s == lim_q) begin
          state_d    = S_OUT;
          out_dec_d  = dec;
          out_iter_d = n_s;
          out_conv_d = 1'b0;
        end else begin
          state_d = S_VNU;
          prev_d  = dec;
          iter_d  = n_s;
        end
      end
      S_OUT: begin
        // abort and start are deliberately ignored until the word is taken.
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
      end
    endcase

    // Strobes follow the next state so each flop is high exactly in its state.
    ld_en_d     = (state_d == S_LOAD);
    vnu_en_d    = (state_d == S_VNU);
    cnu_en_d    = (state_d == S_CNU);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      iter_q      <= '0;
      lim_q       <= '0;
      prev_q      <= '0;
      ld_en_q     <= 1'b0;
      vnu_en_q    <= 1'b0;
      cnu_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_dec_q   <= '0;
      out_iter_q  <= '0;
      out_conv_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      iter_q      <= iter_d;
      lim_q       <= lim_d;
      prev_q      <= prev_d;
      ld_en_q     <= ld_en_d;
      vnu_en_q    <= vnu_en_d;
      cnu_en_q    <= cnu_en_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_dec_q   <= out_dec_d;
      out_iter_q  <= out_iter_d;
      out_conv_q  <= out_conv_d;
    end
  end

  assign ld_en     = ld_en_q;
  assign vnu_en    = vnu_en_q;
  assign cnu_en    = cnu_en_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_dec   = out_dec_q;
  assign out_iter  = out_iter_q;
  assign out_conv  = out_conv_q;

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
// Directed self-checking bench for ldpc_dec_ctrl (default parameters).
// Schedule per iteration: VNU 2 cycles, CNU 2 cycles, CHECK 1 cycle.
module tb_ldpc_dec_ctrl;

  localparam int DW = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [3:0]    max_iter;
  logic [DW-1:0] dec;
  logic          ld_en, vnu_en, cnu_en, busy, out_valid, out_ready, out_conv;
  logic [DW-1:0] out_dec;
  logic [3:0]    out_iter;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] dec_tab [0:15];

  ldpc_dec_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .max_iter  (max_iter),
    .dec       (dec),
    .ld_en     (ld_en),
    .vnu_en    (vnu_en),
    .cnu_en    (cnu_en),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dec   (out_dec),
    .out_iter  (out_iter),
    .out_conv  (out_conv)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; max_iter = 4'd0;
    dec = 40'd0; out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) rst = 1'b0;
      step();
      checks++;
      if ({ld_en, vnu_en, cnu_en, busy, out_valid, out_conv} !== 6'b0 ||
          out_dec !== 40'd0 || out_iter !== 4'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d: got en/busy/ov/conv=%b dec=%h iter=%0d, want all 0",
                 i, {ld_en, vnu_en, cnu_en, busy, out_valid, out_conv}, out_dec, out_iter);
      end
    end
  endtask

  // Runs one frame expected to finish after exp_iter iterations; dec_tab[j]
  // is driven during CHECK j. hold = cycles of out_ready=0 in OUT.
  task automatic run_frame(input logic [3:0] mi, input int exp_iter,
                           input logic exp_conv, input logic [DW-1:0] exp_dec,
                           input int hold, input logic ab_start, input string name);
    logic [4:0] exp_v;
    start = 1'b1; max_iter = mi; abort = ab_start;
    step();
    start = 1'b0; abort = 1'b0; max_iter = 4'hf;
    for (int c = 1; c <= 1 + 5 * exp_iter; c++) begin
      int k;
      k = (c - 2) % 5;
      if (c == 1) exp_v = 5'b10010;
      else if (k < 2) exp_v = 5'b01010;
      else if (k < 4) exp_v = 5'b00110;
      else exp_v = 5'b00010;
      if (c >= 2 && k == 4) dec = dec_tab[(c - 2) / 5];
      else dec = {$urandom, 8'h00};
      checks++;
      if ({ld_en, vnu_en, cnu_en, busy, out_valid} !== exp_v) begin
        failures++;
        $display("FAIL %s sched c=%0d: got ld/vnu/cnu/busy/ov=%b want %b",
                 name, c, {ld_en, vnu_en, cnu_en, busy, out_valid}, exp_v);
      end
      step();
    end
    dec = 40'hff_ffff_ffff;
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if ({ld_en, vnu_en, cnu_en, busy, out_valid} !== 5'b00011 ||
          out_dec !== exp_dec || out_iter !== exp_iter[3:0] || out_conv !== exp_conv) begin
        failures++;
        $display("FAIL %s out h=%0d: got flags=%b dec=%h iter=%0d conv=%b want 00011 %h %0d %b",
                 name, h, {ld_en, vnu_en, cnu_en, busy, out_valid}, out_dec, out_iter,
                 out_conv, exp_dec, exp_iter, exp_conv);
      end
      if (h < hold) begin
        out_ready = 1'b0; start = h[0]; abort = ~h[0];
        step();
      end
    end
    // Handshake cycle, with start pulsed to show it is ignored.
    out_ready = 1'b1; start = 1'b1; abort = 1'b0;
    step();
    out_ready = 1'b0; start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ld_en, vnu_en, cnu_en, busy, out_valid} !== 5'b0 ||
          out_dec !== exp_dec || out_iter !== exp_iter[3:0] || out_conv !== exp_conv) begin
        failures++;
        $display("FAIL %s after_hs i=%0d: got flags=%b dec=%h iter=%0d conv=%b",
                 name, i, {ld_en, vnu_en, cnu_en, busy, out_valid}, out_dec, out_iter, out_conv);
      end
      step();
    end
  endtask

  task automatic test_limit_run();
    dec_tab[0] = 40'h11_1111_1111; dec_tab[1] = 40'h22_2222_2222; dec_tab[2] = 40'h33_3333_3333;
    run_frame(4'd3, 3, 1'b0, 40'h33_3333_3333, 0, 1'b0, "limit_run");
  endtask

  task automatic test_early_term();
    dec_tab[0] = 40'h12_3456_789a; dec_tab[1] = 40'h12_3456_789a;
    run_frame(4'd10, 2, 1'b1, 40'h12_3456_789a, 0, 1'b0, "early_term");
  endtask

  task automatic test_zero_limit();
    // abort alongside start in IDLE: start must win.
    dec_tab[0] = 40'h5a_a5a5_5a5a;
    run_frame(4'd0, 1, 1'b0, 40'h5a_a5a5_5a5a, 0, 1'b1, "zero_limit");
  endtask

  task automatic test_first_iter_guard();
    // Iteration 1 equals the vector left from an earlier frame; must not stop.
    dec_tab[0] = 40'h12_3456_789a; dec_tab[1] = 40'h00_0000_0007;
    run_frame(4'd2, 2, 1'b0, 40'h00_0000_0007, 0, 1'b0, "first_iter_guard");
  endtask

  task automatic test_conv_at_limit();
    dec_tab[0] = 40'haa_0000_0001; dec_tab[1] = 40'hbb_0000_0002; dec_tab[2] = 40'hbb_0000_0002;
    run_frame(4'd3, 3, 1'b1, 40'hbb_0000_0002, 0, 1'b0, "conv_at_limit");
  endtask

  task automatic test_abort();
    start = 1'b1; max_iter = 4'd5;
    step();
    start = 1'b0;
    dec = 40'h01_0203_0405;
    // Cycle 1 after start is LOAD; cycle 9 is the first CNU cycle of iteration 2.
    for (int c = 1; c < 9; c++) begin
      dec = dec + 40'd1;
      step();
    end
    checks++;
    if (cnu_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort pre: got cnu_en=%b busy=%b want 1 1", cnu_en, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if ({ld_en, vnu_en, cnu_en, busy, out_valid} !== 5'b0 || out_dec !== 40'hbb_0000_0002) begin
        failures++;
        $display("FAIL abort idle i=%0d: got flags=%b dec=%h want 00000 bb00000002",
                 i, {ld_en, vnu_en, cnu_en, busy, out_valid}, out_dec);
      end
      step();
    end
    dec_tab[0] = 40'h77_6655_4433;
    run_frame(4'd1, 1, 1'b0, 40'h77_6655_4433, 0, 1'b0, "after_abort");
  endtask

  task automatic test_back_pressure();
    dec_tab[0] = 40'hde_adbe_ef01;
    run_frame(4'd1, 1, 1'b0, 40'hde_adbe_ef01, 5, 1'b0, "back_pressure");
  endtask

  task automatic test_back_to_back();
    dec_tab[0] = 40'h00_0000_0000; dec_tab[1] = 40'hff_0000_ffff;
    run_frame(4'd2, 2, 1'b0, 40'hff_0000_ffff, 0, 1'b0, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_limit_run();
    test_early_term();
    test_zero_limit();
    test_first_iter_guard();
    test_conv_at_limit();
    test_abort();
    test_back_pressure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
